// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier: WIDTH cycles of CALC plus one FIX cycle.
// Define MULT_SIGNED_EN to honour mult_sign; otherwise every operation is unsigned.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [5:0]         count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] product;

`ifdef MULT_SIGNED_EN
  logic sign_in;
  logic neg;

  // Signed operands become magnitudes; the most-negative value maps onto itself,
  // which is exactly its magnitude when read as unsigned.
  always_comb begin
    mag_a   = (mult_sign && srca[WIDTH-1]) ? -srca : srca;
    mag_b   = (mult_sign && srcb[WIDTH-1]) ? -srcb : srcb;
    sign_in = mult_sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
  end

  assign product = neg ? -acc : acc;
`else
  logic unused_mult_sign;

  assign unused_mult_sign = mult_sign;
  assign mag_a            = srca;
  assign mag_b            = srcb;
  assign product          = acc;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: default assigned before the case so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_mult) state_next = CALC;
      CALC:    if (count == 6'd1) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every register here, datapath included, is cleared by reset so an aborted
  // operation leaves nothing behind; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            count  <= 6'(WIDTH);
`ifdef MULT_SIGNED_EN
            neg    <= sign_in;
`endif
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 6'd1;
        end
        FIX: begin
          {hi, lo} <= product;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed corner cases plus random operands
// compared against a plain-arithmetic product model.
module tb_mult_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start_mult;
  logic             mult_sign;
  logic [WIDTH-1:0] srca, srcb;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] last;

  mult_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_mult (start_mult),
    .mult_sign  (mult_sign),
    .srca       (srca),
    .srcb       (srcb),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
`ifdef MULT_SIGNED_EN
    if (s) return 64'(sa * sb);
`endif
    if (s && sa == sb) return ua * ub;  // keeps sa/sb used in the unsigned-only build
    return ua * ub;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle request at the current falling edge; returns at the falling edge after E0.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    start_mult = 1'b1;
    srca       = a;
    srcb       = b;
    mult_sign  = s;
    @(negedge clk);
    start_mult = 1'b0;
    srca       = $urandom;
    srcb       = $urandom;
    mult_sign  = 1'($urandom_range(0, 1));
  endtask

  // Wait (bounded) for done; checks latency, continuous busy, held outputs and the result.
  task automatic finish_op(input string tag, input logic [63:0] exp, input bit intrude);
    int k = 0;
    bit busy_ok = 1'b1;
    bit hold_ok = 1'b1;
    while (!done && k < 40) begin
      if (!busy) busy_ok = 1'b0;
      if ({hi, lo} !== last) hold_ok = 1'b0;
      if (intrude && k == 9) begin
        start_mult = 1'b1;
        srca       = 32'd3;
        srcb       = 32'd3;
        mult_sign  = 1'b0;
      end
      if (k == 10) start_mult = 1'b0;
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'd33);
    check({tag, "_busy_held"}, {63'b0, busy_ok}, 64'd1);
    check({tag, "_hilo_held"}, {63'b0, hold_ok}, 64'd1);
    check({tag, "_result"}, {hi, lo}, exp);
    check({tag, "_busy_low"}, {63'b0, busy}, 64'd0);
    last = exp;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    launch(a, b, s);
    finish_op(tag, model(a, b, s), 1'b0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    reset_n    = 1'b0;
    start_mult = 1'b0;
    mult_sign  = 1'b0;
    srca       = '0;
    srcb       = '0;
    last       = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {60'b0, busy, done, |hi, |lo}, 64'd0);
    reset_n = 1'b1;

    // Directed cases; the model supplies the signed/unsigned expectation for the build.
    run("u7x6", 32'd7, 32'd6, 1'b0);
    check("u7x6_const", {hi, lo}, 64'h0000_0000_0000_002A);
    run("uffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("uffxff_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run("s_neg2x3", 32'hFFFF_FFFE, 32'd3, 1'b1);
`ifdef MULT_SIGNED_EN
    check("s_neg2x3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
`else
    check("s_neg2x3_const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
`endif
    run("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
    check("s_minxmin_const", {hi, lo}, 64'h4000_0000_0000_0000);

    // Start while busy is ignored, then back-to-back start on the done cycle.
    launch(32'd5, 32'd5, 1'b0);
    finish_op("ignore_busy", 64'h19, 1'b1);
    ra = $urandom;
    rb = $urandom;
    rs = 1'($urandom_range(0, 1));
    launch(ra, rb, rs);
    check("b2b_done_pulse", {63'b0, done}, 64'd0);
    finish_op("b2b", model(ra, rb, rs), 1'b0);
    @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    launch(32'd9, 32'd9, 1'b0);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("abort_state", {60'b0, busy, done, |hi, |lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    last    = '0;
    ra = $urandom;
    rb = $urandom;
    launch(ra, rb, 1'b0);
    finish_op("post_reset", model(ra, rb, 1'b0), 1'b0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'h0;
      run($sformatf("rand%0d", i), ra, rb, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
